// File: rtl/vga_text_writer.sv
// rtl/vga_text_writer.sv - byte-stream writer for the VGA text character RAM
// Registered write port; outputs describe the action of the current state.
`timescale 1ns/1ps
module vga_text_writer #(
  parameter int         COLS  = 16,
  parameter int         ROWS  = 8,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic       px_clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       valid,
  input  logic       hex,
  output logic       ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] cur_col,
  output logic [7:0] cur_row,
  output logic       busy
);

  localparam logic [7:0] LAST_COL  = 8'(COLS - 1);
  localparam logic [7:0] LAST_ROW  = 8'(ROWS - 1);
  localparam logic [7:0] LAST_CELL = 8'(COLS * ROWS - 1);
  // Wraps to 0 only when COLS=256, where ROWS=1 keeps the row term zero
  localparam logic [7:0] COLS8     = 8'(COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_HEX_HI,
    S_HEX_LO,
    S_CLEAR
  } state_t;

  state_t     r_state,   w_state_nxt;
  logic [7:0] r_byte,    w_byte_nxt;
  logic [7:0] r_col,     w_col_nxt;
  logic [7:0] r_row,     w_row_nxt;
  logic [7:0] r_cnt,     w_cnt_nxt;
  logic       r_wr_en,   w_wr_en_nxt;
  logic [7:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0] r_wr_data, w_wr_data_nxt;

  logic       w_xfer;
  logic [7:0] w_nl_row;
  logic [7:0] w_adv_col;
  logic [7:0] w_adv_row;
  logic [7:0] w_cur_addr;
  logic [7:0] w_adv_addr;

  assign w_xfer     = valid && (r_state == S_IDLE);
  assign w_nl_row   = (r_row == LAST_ROW) ? 8'd0 : r_row + 8'd1;
  assign w_adv_col  = (r_col == LAST_COL) ? 8'd0 : r_col + 8'd1;
  assign w_adv_row  = (r_col == LAST_COL) ? w_nl_row : r_row;
  assign w_cur_addr = r_row * COLS8 + r_col;
  assign w_adv_addr = w_adv_row * COLS8 + w_adv_col;

  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_byte    <= 8'd0;
      r_col     <= 8'd0;
      r_row     <= 8'd0;
      r_cnt     <= 8'd0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 8'd0;
      r_wr_data <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_byte    <= w_byte_nxt;
      r_col     <= w_col_nxt;
      r_row     <= w_row_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_byte_nxt    = r_byte;
    w_col_nxt     = r_col;
    w_row_nxt     = r_row;
    w_cnt_nxt     = r_cnt;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_byte_nxt = din;
          if (hex) begin
            w_state_nxt   = S_HEX_HI;
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = w_cur_addr;
            w_wr_data_nxt = {4'h0, din[7:4]};
          end else if (din == 8'h0C) begin
            w_state_nxt   = S_CLEAR;
            w_cnt_nxt     = 8'd0;
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = 8'd0;
            w_wr_data_nxt = BLANK;
          end else begin
            w_state_nxt = S_EXEC;
            if (din != 8'h0A) begin
              w_wr_en_nxt   = 1'b1;
              w_wr_addr_nxt = w_cur_addr;
              w_wr_data_nxt = din;
            end
          end
        end
      end
      S_EXEC: begin
        w_state_nxt = S_IDLE;
        if (r_byte == 8'h0A) begin
          w_col_nxt = 8'd0;
          w_row_nxt = w_nl_row;
        end else begin
          w_col_nxt = w_adv_col;
          w_row_nxt = w_adv_row;
        end
      end
      S_HEX_HI: begin
        w_state_nxt   = S_HEX_LO;
        w_col_nxt     = w_adv_col;
        w_row_nxt     = w_adv_row;
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = w_adv_addr;
        w_wr_data_nxt = {4'h0, r_byte[3:0]};
      end
      S_HEX_LO: begin
        w_state_nxt = S_IDLE;
        w_col_nxt   = w_adv_col;
        w_row_nxt   = w_adv_row;
      end
      S_CLEAR: begin
        // Coming out of reset the write strobe is low, so cell 0 is issued first
        if (!r_wr_en) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_cnt;
          w_wr_data_nxt = BLANK;
        end else if (r_cnt == LAST_CELL) begin
          w_state_nxt = S_IDLE;
          w_col_nxt   = 8'd0;
          w_row_nxt   = 8'd0;
        end else begin
          w_cnt_nxt     = r_cnt + 8'd1;
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_cnt + 8'd1;
          w_wr_data_nxt = BLANK;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  assign ready   = (r_state == S_IDLE);
  assign busy    = (r_state == S_CLEAR);
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign cur_col = r_col;
  assign cur_row = r_row;

endmodule

// File: tb/tb_vga_text_writer.sv
// tb/tb_vga_text_writer.sv - scoreboard bench for vga_text_writer
// Reference model tracks the cursor as a linear cell index modulo the screen size.
`timescale 1ns/1ps
module tb_vga_text_writer;
  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int N    = COLS * ROWS;
  localparam logic [7:0] BLANK = 8'h20;

  logic       px_clk = 1'b0;
  logic       rst    = 1'b1;
  logic [7:0] din    = 8'd0;
  logic       valid  = 1'b0;
  logic       hex    = 1'b0;
  logic       ready, wr_en, busy;
  logic [7:0] wr_addr, wr_data, cur_col, cur_row;

  int n_checks = 0;
  int n_fail   = 0;
  int m_pos    = 0;
  logic [15:0] exp_q[$];

  vga_text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .px_clk (px_clk),
    .rst    (rst),
    .din    (din),
    .valid  (valid),
    .hex    (hex),
    .ready  (ready),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .cur_col(cur_col),
    .cur_row(cur_row),
    .busy   (busy)
  );

  always #5 px_clk = ~px_clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge px_clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", wr_addr, wr_data);
      end else begin
        check("write_addr_data", int'({wr_addr, wr_data}), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic model(input logic [7:0] b, input logic h,
                       output int ex_n, output int ex_wr, output bit ex_busy);
    ex_busy = 1'b0;
    if (h) begin
      exp_q.push_back({8'(m_pos), 4'h0, b[7:4]});
      m_pos = (m_pos + 1) % N;
      exp_q.push_back({8'(m_pos), 4'h0, b[3:0]});
      m_pos = (m_pos + 1) % N;
      ex_n = 3; ex_wr = 2;
    end else if (b == 8'h0C) begin
      for (int a = 0; a < N; a++) exp_q.push_back({8'(a), BLANK});
      m_pos = 0;
      ex_n = N + 1; ex_wr = N; ex_busy = 1'b1;
    end else if (b == 8'h0A) begin
      m_pos = (((m_pos / COLS) + 1) % ROWS) * COLS;
      ex_n = 2; ex_wr = 0;
    end else begin
      exp_q.push_back({8'(m_pos), b});
      m_pos = (m_pos + 1) % N;
      ex_n = 2; ex_wr = 1;
    end
  endtask

  // Called just after a transfer (or reset) edge; returns at the negedge where ready is seen
  task automatic wait_idle(input int ex_n, input int ex_wr, input bit ex_busy, input string nm);
    int n = 0, wr = 0, bs = 0;
    do begin
      @(negedge px_clk);
      n++;
      if (!ready) begin
        if (busy)  bs++;
        if (wr_en) wr++;
      end
    end while (!ready && n < 2000);
    check({nm, "_ready_latency"}, n, ex_n);
    check({nm, "_write_count"}, wr, ex_wr);
    check({nm, "_busy_cycles"}, bs, ex_busy ? ex_n - 1 : 0);
    check({nm, "_cur_col"}, int'(cur_col), m_pos % COLS);
    check({nm, "_cur_row"}, int'(cur_row), m_pos / COLS);
  endtask

  task automatic send(input logic [7:0] b, input logic h, input string nm);
    int en, ew, g;
    bit eb;
    g = 0;
    while (!ready && g < 2000) begin @(negedge px_clk); g++; end
    model(b, h, en, ew, eb);
    din = b; hex = h; valid = 1'b1;
    @(posedge px_clk); #1;
    valid = 1'b0;
    wait_idle(en, ew, eb, nm);
  endtask

  task automatic goto_pos(input int p);
    while (m_pos != p) send(8'($urandom_range(8'h21, 8'h7E)), 1'b0, "fill");
  endtask

  // Expects rst already driven high
  task automatic apply_reset(input string nm);
    @(posedge px_clk); #1;
    check({nm, "_wr_en"}, int'(wr_en), 0);
    check({nm, "_busy"}, int'(busy), 1);
    check({nm, "_ready"}, int'(ready), 0);
    check({nm, "_wr_addr"}, int'(wr_addr), 0);
    check({nm, "_wr_data"}, int'(wr_data), 0);
    check({nm, "_cur_col"}, int'(cur_col), 0);
    check({nm, "_cur_row"}, int'(cur_row), 0);
    rst = 1'b0;
    exp_q.delete();
    for (int a = 0; a < N; a++) exp_q.push_back({8'(a), BLANK});
    m_pos = 0;
    wait_idle(N + 2, N, 1'b1, nm);
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int en, ew, r;
    bit eb;
    logic [7:0] b;
    logic h;

    rst = 1'b1;
    apply_reset("reset");

    send(8'h41, 1'b0, "char_A");
    goto_pos(15);
    send(8'hA5, 1'b1, "hex_A5");
    goto_pos(7 * COLS + 3);
    send(8'h0A, 1'b0, "nl_last_row");
    goto_pos(N - 1);
    send(8'h42, 1'b0, "wrap_last_cell");
    send(8'h0C, 1'b1, "hex_0C_data");
    send(8'h0A, 1'b1, "hex_0A_data");

    // Clear with valid held high: the waiting byte must land only after the clear
    goto_pos(40);
    model(8'h0C, 1'b0, en, ew, eb);
    din = 8'h0C; hex = 1'b0; valid = 1'b1;
    @(posedge px_clk); #1;
    din = 8'h33;
    wait_idle(en, ew, eb, "clear_cmd");
    model(8'h33, 1'b0, en, ew, eb);
    @(posedge px_clk); #1;
    valid = 1'b0;
    wait_idle(en, ew, eb, "held_valid");

    // Reset while the low nibble is being written
    goto_pos(20);
    model(8'h3C, 1'b1, en, ew, eb);
    din = 8'h3C; hex = 1'b1; valid = 1'b1;
    @(posedge px_clk); #1;
    valid = 1'b0;
    @(posedge px_clk); #1;
    rst = 1'b1;
    apply_reset("rst_hex_lo");

    // Reset part-way through a clear
    goto_pos(50);
    model(8'h0C, 1'b0, en, ew, eb);
    din = 8'h0C; hex = 1'b0; valid = 1'b1;
    @(posedge px_clk); #1;
    valid = 1'b0;
    repeat (40) @(posedge px_clk);
    #1;
    rst = 1'b1;
    apply_reset("rst_mid_clear");

    for (int i = 0; i < 80; i++) begin
      h = 1'($urandom_range(0, 1));
      b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 19);
      if (r == 0) begin b = 8'h0C; h = 1'b0; end
      else if (r < 3) begin b = 8'h0A; h = 1'b0; end
      send(b, h, "random");
    end

    repeat (5) @(negedge px_clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
